sha_sigma_u1_inv_gadget: RTL
============================

SHA_SIGMA_U1_INV_GADGET -- requirements
Module: sha_sigma_u1_inv_gadget

Interface
REQ-001 Parameter d, default 2: number of Boolean shares per bit (d >= 2).
REQ-002 Localparam word = 64, fixed.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_valid  input  1  x_input and mode are valid.
REQ-006 in_ready  output  1  block accepts a new operand.
REQ-007 mode  input  1  0 = forward Sigma1 (one application); 1 = inverse Sigma1.
REQ-008 x_input  input  d*word  masked operand; share j of bit i at index i*d+j.
REQ-009 out_valid  output  1  out_x holds a completed result.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 out_x  output  d*word  masked result, same share layout as x_input.

Function
REQ-012 L(x) = rotr14(x) XOR rotr18(x) XOR rotr41(x), rotations on unmasked bit index; L SHALL be applied share-wise by rotating whole d-bit bit-groups, with no cross-share mixing and no randomness.
REQ-013 Inverse SHALL be computed as L applied 63 times (L^64 = identity over GF(2)[x]/(x^64+1)).
REQ-014 FSM states: IDLE, RUN, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-015 IDLE: in_valid high at an edge -> load x_input into data register, iteration counter = 0, latch mode, go to RUN.
REQ-016 RUN: each edge applies L once to the data register and increments the counter.
REQ-017 RUN -> DONE on the edge completing the 1st application (mode 0) or the 63rd application (mode 1).
REQ-018 Latency from accept edge T: out_valid high after edge T+1 (mode 0), after edge T+63 (mode 1).
REQ-019 DONE: out_x and out_valid held stable until out_valid and out_ready both high at an edge -> IDLE.
REQ-020 A new operand SHALL be accepted no earlier than the edge after the result handshake; in_valid is ignored outside IDLE.
REQ-021 Counter is 6 bits, never wraps; it stops at 63 and is cleared on the next accept.
REQ-022 out_x SHALL drive the data register directly (no combinational path from x_input to out_x).
REQ-023 Recombined output SHALL depend only on recombined input; per-share output depends only on the same share of input.

Reset
REQ-024 rst high at an edge -> state IDLE, data register all zero, counter 0, latched mode 0; overrides all other inputs.
REQ-025 After reset: in_ready = 1, out_valid = 0, out_x = 0.
REQ-026 rst asserted during RUN or DONE aborts the operation; the pending result is discarded and never presented.

Verification
REQ-027 d=2, mode 1, recombined input 0x0004400000800000 (share1 random, share0 = value XOR share1) -> out_valid 63 cycles after accept, recombined out_x = 0x0000000000000001.
REQ-028 d=2, mode 0, recombined input 0x0000000000000001 -> out_valid 1 cycle after accept, recombined out_x = 0x0004400000800000.
REQ-029 Round trip: 1000 random 64-bit values, random masks, mode 0 then its output fed with fresh remask in mode 1 -> recombined result equals original value; d=3 run also passes.
REQ-030 Backpressure: out_ready held low 10 cycles in DONE -> out_x stable, in_ready 0, extra in_valid pulses ignored; out_ready high -> IDLE next edge, in_ready 1.
REQ-031 Reset mid-RUN at iteration 30 -> next cycle in_ready 1, out_valid 0, out_x 0; next accepted operand completes with correct value and full 63-cycle latency.
REQ-032 Share independence: all-zero share 1 with share 0 = v -> share 1 of out_x stays all zero, share 0 equals plain L^63(v).

Source files
------------

// File: rtl/sha_sigma_u1_inv_gadget.sv
// Masked SHA-512 Sigma1 linear layer and its inverse.
// L(x) = rotr14(x) ^ rotr18(x) ^ rotr41(x), applied share-wise on a
// bit-interleaved layout (share j of bit i sits at index i*d+j).
// The inverse is L^63 because L^64 is the identity. It is computed
// iteratively, one application of L per clock.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for an operand, in_ready high
// RUN   | applying L once per cycle to the data register
// DONE  | result held on out_x, out_valid high until out_ready
module sha_sigma_u1_inv_gadget #(
    parameter int d = 2,
    localparam int word = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mode,
    input  logic [d*word-1:0] x_input,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [d*word-1:0] out_x
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [d*word-1:0] data_q;
    logic [5:0]        cnt_q;
    logic              mode_q;
    logic              last_iter;

    // Rotates whole d-bit groups, so shares never mix with each other.
    function automatic logic [d*word-1:0] sigma_l(input logic [d*word-1:0] x);
        logic [d*word-1:0] y;
        int s14;
        int s18;
        int s41;
        y = '0;
        for (int i = 0; i < word; i++) begin
            s14 = (i + 14) % word;
            s18 = (i + 18) % word;
            s41 = (i + 41) % word;
            for (int j = 0; j < d; j++) begin
                y[i*d+j] = x[s14*d+j] ^ x[s18*d+j] ^ x[s41*d+j];
            end
        end
        return y;
    endfunction

    // The counter holds the number of applications already done, so the
    // edge taking it to the target count is the last one.
    assign last_iter = mode_q ? (cnt_q == 6'd62) : (cnt_q == 6'd0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_iter) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: load on accept, one L application per RUN cycle.
    // The counter saturates at 63 and never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            cnt_q  <= 6'd0;
            mode_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q <= x_input;
                        cnt_q  <= 6'd0;
                        mode_q <= mode;
                    end
                end
                RUN: begin
                    data_q <= sigma_l(data_q);
                    if (cnt_q != 6'd63) begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_x     = data_q;

endmodule
